// File: rtl/l1_response_router.sv
// -----------------------------------------------------------------------------
// l1_response_router
//
// Return path of the L1 arbiter. Each read request the arbiter issues is
// logged as {requester id, burst length} in a small circular FIFO, in issue
// order. Memory read words come back in order. Each word is steered to the
// requester at the FIFO head, one cycle after it arrives. When the head's
// final word has been forwarded, the head entry is popped.
//
// Ports
//   clk            core clock
//   rst            synchronous, active-high reset
//   req_push       arbiter issued a read request this cycle
//   req_id         requester id of the pushed request
//   req_len        burst length minus one of the pushed request
//   req_full       FIFO full, arbiter must not push
//   mem_rvalid     memory read word valid
//   mem_rdata      memory read word
//   rd_valid       one-hot per-requester data valid
//   rd_data        read word, broadcast to all requesters
//   rd_word_idx    word position within the burst
//   rd_last        final word of the burst
//   protocol_error sticky: push while full, or read word with nothing pending
//
// Optional build macro L1_RESPONSE_ROUTER_STATS_EN adds:
//   max_occupancy  high-water mark of the FIFO count
//   words_routed   number of forwarded words, wraps at 2^32
// -----------------------------------------------------------------------------
module l1_response_router #(
   parameter int unsigned L1_CONNECTIONS  = 4,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned MAX_BURST_W     = 4,
   parameter int unsigned DATA_W          = 32,
   localparam int unsigned ID_W  = $clog2(L1_CONNECTIONS),
   localparam int unsigned LEN_W = $clog2(MAX_BURST_W),
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_push,
   input  logic [ID_W-1:0]           req_id,
   input  logic [LEN_W-1:0]          req_len,
   output logic                      req_full,
   input  logic                      mem_rvalid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [L1_CONNECTIONS-1:0] rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic [LEN_W-1:0]          rd_word_idx,
   output logic                      rd_last,
   output logic                      protocol_error
`ifdef L1_RESPONSE_ROUTER_STATS_EN
   ,
   output logic [CNT_W-1:0]          max_occupancy,
   output logic [31:0]               words_routed
`endif
);

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [LEN_W-1:0] len;
   } entry_t;

   entry_t                    fifo_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]          head_q, head_d;
   logic [PTR_W-1:0]          tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [LEN_W-1:0]          word_cnt_q, word_cnt_d;
   logic [L1_CONNECTIONS-1:0] rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]         rd_data_q, rd_data_d;
   logic [LEN_W-1:0]          rd_word_idx_q, rd_word_idx_d;
   logic                      rd_last_q, rd_last_d;
   logic                      error_q, error_d;

   entry_t head_entry;
   logic   fifo_empty;
   logic   push_ok;
   logic   route;
   logic   burst_end;
   logic   pop;

   assign req_full   = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign head_entry = fifo_q[head_q];

   // NOTE: every variable driven here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      // A pop in the same cycle does not free a slot for this push.
      push_ok   = req_push && !req_full;
      // Emptiness is judged before this cycle's push: a request is only
      // routable from the cycle after it was pushed.
      route     = mem_rvalid && !fifo_empty;
      burst_end = (word_cnt_q == head_entry.len);
      pop       = route && burst_end;

      head_d        = head_q;
      tail_d        = tail_q;
      word_cnt_d    = word_cnt_q;
      rd_valid_d    = '0;
      rd_data_d     = rd_data_q;
      rd_word_idx_d = rd_word_idx_q;
      rd_last_d     = rd_last_q;
      error_d       = error_q;

      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

      // Pointers wrap by natural overflow of their PTR_W-bit width.
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      if (pop)     head_d = head_q + PTR_W'(1);

      if (route) begin
         rd_valid_d    = L1_CONNECTIONS'(1) << head_entry.id;
         rd_data_d     = mem_rdata;
         rd_word_idx_d = word_cnt_q;
         rd_last_d     = burst_end;
         word_cnt_d    = burst_end ? '0 : word_cnt_q + LEN_W'(1);
      end

      if ((req_push && req_full) || (mem_rvalid && fifo_empty)) error_d = 1'b1;
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         word_cnt_q    <= '0;
         rd_valid_q    <= '0;
         rd_data_q     <= '0;
         rd_word_idx_q <= '0;
         rd_last_q     <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         word_cnt_q    <= word_cnt_d;
         rd_valid_q    <= rd_valid_d;
         rd_data_q     <= rd_data_d;
         rd_word_idx_q <= rd_word_idx_d;
         rd_last_q     <= rd_last_d;
         error_q       <= error_d;
      end
   end

   // NOTE: the storage array is not reset; an entry is only read after it
   // has been written, because count gates every read of the head.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) fifo_q[tail_q] <= '{id: req_id, len: req_len};
   end

   assign rd_valid       = rd_valid_q;
   assign rd_data        = rd_data_q;
   assign rd_word_idx    = rd_word_idx_q;
   assign rd_last        = rd_last_q;
   assign protocol_error = error_q;

`ifdef L1_RESPONSE_ROUTER_STATS_EN
   logic [CNT_W-1:0] max_occ_q;
   logic [31:0]      words_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         max_occ_q <= '0;
         words_q   <= '0;
      end else begin
         if (count_q > max_occ_q) max_occ_q <= count_q;
         if (route)               words_q   <= words_q + 32'd1;
      end
   end

   assign max_occupancy = max_occ_q;
   assign words_routed  = words_q;
`endif

endmodule

// File: tb/tb_l1_response_router.sv
// -----------------------------------------------------------------------------
// tb_l1_response_router
//
// Drives directed scenarios followed by randomized traffic into
// l1_response_router. A queue-based reference model of the outstanding
// requests predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_l1_response_router;

   localparam int unsigned NCONN = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_push;
   logic [1:0]    req_id;
   logic [1:0]    req_len;
   logic          req_full;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [3:0]    rd_valid;
   logic [DW-1:0] rd_data;
   logic [1:0]    rd_word_idx;
   logic          rd_last;
   logic          protocol_error;
`ifdef L1_RESPONSE_ROUTER_STATS_EN
   logic [2:0]    max_occupancy;
   logic [31:0]   words_routed;
`endif

   l1_response_router #(
      .L1_CONNECTIONS (NCONN),
      .MAX_OUTSTANDING(DEPTH),
      .MAX_BURST_W    (4),
      .DATA_W         (DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_push      (req_push),
      .req_id        (req_id),
      .req_len       (req_len),
      .req_full      (req_full),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_word_idx   (rd_word_idx),
      .rd_last       (rd_last),
      .protocol_error(protocol_error)
`ifdef L1_RESPONSE_ROUTER_STATS_EN
      ,
      .max_occupancy (max_occupancy),
      .words_routed  (words_routed)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue of outstanding requests plus words already
   // delivered for the oldest one.
   typedef struct {
      logic [1:0] id;
      logic [1:0] len;
   } req_t;

   req_t        pend[$];
   int          served;
   logic [3:0]  m_valid;
   logic [31:0] m_data;
   logic [1:0]  m_idx;
   logic        m_last;
   logic        m_err;
   int          m_max;
   int          m_words;

   function automatic void model_clear();
      pend.delete();
      served  = 0;
      m_valid = '0;
      m_data  = '0;
      m_idx   = '0;
      m_last  = 1'b0;
      m_err   = 1'b0;
      m_max   = 0;
      m_words = 0;
   endfunction

   function automatic void model_cycle(input bit push, input logic [1:0] id,
                                       input logic [1:0] len, input bit rv,
                                       input logic [31:0] data);
      int  occ   = pend.size();
      bit  full  = (occ == DEPTH);
      bit  empty = (occ == 0);
      if (occ > m_max) m_max = occ;
      m_valid = '0;
      if (rv) begin
         if (empty) begin
            m_err = 1'b1;
         end else begin
            m_valid = 4'(1) << pend[0].id;
            m_data  = data;
            m_idx   = 2'(served);
            m_last  = (served == int'(pend[0].len));
            m_words++;
            if (m_last) begin
               void'(pend.pop_front());
               served = 0;
            end else begin
               served++;
            end
         end
      end
      if (push) begin
         if (full) m_err = 1'b1;
         else      pend.push_back('{id: id, len: len});
      end
   endfunction

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input bit push, input logic [1:0] id, input logic [1:0] len,
                       input bit rv, input logic [31:0] data, input bit do_rst);
      rst        = do_rst;
      req_push   = push;
      req_id     = id;
      req_len    = len;
      mem_rvalid = rv;
      mem_rdata  = data;
      if (do_rst) model_clear();
      else        model_cycle(push, id, len, rv, data);
      @(posedge clk);
      #1;
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      check("rd_data", 64'(rd_data), 64'(m_data));
      check("rd_word_idx", 64'(rd_word_idx), 64'(m_idx));
      check("rd_last", 64'(rd_last), 64'(m_last));
      check("protocol_error", 64'(protocol_error), 64'(m_err));
      check("req_full", 64'(req_full), 64'(pend.size() == DEPTH));
`ifdef L1_RESPONSE_ROUTER_STATS_EN
      check("max_occupancy", 64'(max_occupancy), 64'(m_max));
      check("words_routed", 64'(words_routed), 64'(m_words));
`endif
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic push_req(input logic [1:0] id, input logic [1:0] len);
      step(1'b1, id, len, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic word(input logic [31:0] data);
      step(1'b0, 2'd0, 2'd0, 1'b1, data, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; req_push = 1'b0; req_id = '0; req_len = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      model_clear();

      // Reset state.
      do_reset();
      do_reset();
      check("reset_rd_valid", 64'(rd_valid), 64'h0);
      check("reset_req_full", 64'(req_full), 64'h0);

      // Single word.
      push_req(2'd1, 2'd0);
      word(32'hDEADBEEF);
      check("single_valid", 64'(rd_valid), 64'b0010);
      check("single_data", 64'(rd_data), 64'hDEADBEEF);
      check("single_last", 64'(rd_last), 64'h1);
      idle();

      // Burst of four words.
      push_req(2'd0, 2'd3);
      for (int i = 0; i < 4; i++) word(32'hA000_0000 + 32'(i));
      check("burst_last_idx", 64'(rd_word_idx), 64'h3);
      idle();

      // Interleaved owners.
      push_req(2'd2, 2'd0);
      push_req(2'd3, 2'd1);
      push_req(2'd0, 2'd0);
      word(32'h1111_0000);
      check("inter_v0", 64'(rd_valid), 64'b0100);
      word(32'h1111_0001);
      check("inter_v1", 64'(rd_valid), 64'b1000);
      word(32'h1111_0002);
      check("inter_v2", 64'(rd_valid), 64'b1000);
      word(32'h1111_0003);
      check("inter_v3", 64'(rd_valid), 64'b0001);
      check("inter_err", 64'(protocol_error), 64'h0);

      // Full, overflow push, drain, then wrap the pointers.
      for (int i = 0; i < 4; i++) push_req(2'(i), 2'd0);
      check("full_flag", 64'(req_full), 64'h1);
      push_req(2'd1, 2'd0);
      check("overflow_err", 64'(protocol_error), 64'h1);
      for (int i = 0; i < 4; i++) word(32'hB000_0000 + 32'(i));
      for (int i = 0; i < 6; i++)
         step(1'b1, 2'((i + 3) % 4), 2'd0, i > 0, 32'hC000_0000 + 32'(i), 1'b0);
      word(32'hC000_0010);
      idle();

      // Unexpected responses, sticky error, cleared by reset.
      do_reset();
      word(32'hBAD0_0001);
      check("unexp_err", 64'(protocol_error), 64'h1);
      idle();
      step(1'b1, 2'd2, 2'd0, 1'b1, 32'hBAD0_0002, 1'b0);
      word(32'h5555_0000);
      check("late_route", 64'(rd_valid), 64'b0100);
      do_reset();
      check("err_cleared", 64'(protocol_error), 64'h0);

      // Reset mid-burst.
      push_req(2'd1, 2'd3);
      word(32'h7000_0000);
      word(32'h7000_0001);
      do_reset();
      check("mid_rst_valid", 64'(rd_valid), 64'h0);
      check("mid_rst_full", 64'(req_full), 64'h0);
      push_req(2'd3, 2'd0);
      word(32'h7000_0002);
      check("mid_rst_new_valid", 64'(rd_valid), 64'b1000);
      check("mid_rst_new_idx", 64'(rd_word_idx), 64'h0);

      // Randomized traffic, mostly legal with occasional misuse and resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit          p, r, x;
         logic [1:0]  id, len;
         logic [31:0] d;
         x   = ($urandom_range(0, 199) == 0);
         id  = 2'($urandom_range(0, 3));
         len = 2'($urandom_range(0, 3));
         d   = $urandom;
         if (pend.size() == DEPTH) p = ($urandom_range(0, 49) == 0);
         else                      p = ($urandom_range(0, 99) < 40);
         if (pend.size() == 0)     r = ($urandom_range(0, 49) == 0);
         else                      r = ($urandom_range(0, 99) < 60);
         step(p, id, len, r, d, x);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/l1_response_router.md
Name: l1_response_router

Overview:
- Return-path counterpart to the L1 arbiter's request path.
- Records the L1 requester ID and burst length of each read request the arbiter issues, in issue order.
- Steers each returning memory read word to the requester that owns it: D-cache (0), I-cache (1), DMMU (2) or IMMU (3).
- Sits between the memory/bus read-data channel and the four L1 clients. Memory responses are in order.

Parameters:
- L1_CONNECTIONS, 4, number of L1 requesters; ID width is $clog2(L1_CONNECTIONS).
- MAX_OUTSTANDING, 4, depth of the outstanding-request FIFO; must be a power of 2 and ≥2.
- MAX_BURST_W, 4, maximum words per read burst (cache LINE_W); power of 2.
- DATA_W, 32, read data width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- req_push  in  1  arbiter issued a read request this cycle.
- req_id  in  $clog2(L1_CONNECTIONS)  requester ID of the pushed request.
- req_len  in  $clog2(MAX_BURST_W)  burst length minus 1 (0 = single word).
- req_full  out  1  FIFO full; arbiter must not push.
- mem_rvalid  in  1  memory read word valid.
- mem_rdata  in  DATA_W  memory read word.
- rd_valid  out  L1_CONNECTIONS  one-hot per-requester data valid.
- rd_data  out  DATA_W  read word, broadcast to all requesters.
- rd_word_idx  out  $clog2(MAX_BURST_W)  word position within the burst.
- rd_last  out  1  final word of the burst.
- protocol_error  out  1  sticky error flag.

Behaviour:
- Reset: FIFO empty, head/tail pointers 0, word counter 0, rd_valid=0, rd_data=0, rd_word_idx=0, rd_last=0, protocol_error=0, req_full=0.
- FIFO storage:
  - Entry = {id, len}; circular, MAX_OUTSTANDING entries.
  - Count register width $clog2(MAX_OUTSTANDING)+1.
  - Pointers wrap modulo MAX_OUTSTANDING via natural overflow.
- req_full = (count == MAX_OUTSTANDING); purely combinational from registered count.
- Push:
  - Accepted when req_push && !req_full.
  - req_push while full is ignored and sets protocol_error. A pop in the same cycle does not make room.
- Response handling (on mem_rvalid):
  - FIFO non-empty: next cycle assert rd_valid[head.id]=1, rd_data=mem_rdata, rd_word_idx=word counter, rd_last=(counter==head.len). Latency is exactly 1 cycle; no backpressure, clients must accept.
  - If counter==head.len: pop head, counter←0. Otherwise counter←counter+1.
  - FIFO empty: word dropped, rd_valid stays 0, protocol_error set. This includes the case where req_push arrives in the same cycle; a request is routable starting the cycle after its push.
- Without mem_rvalid: rd_valid←0 each cycle. rd_data, rd_word_idx and rd_last hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- protocol_error is sticky until rst.
- rst mid-burst: all state discarded and outputs return to reset values on the next edge. In-flight memory words arriving after reset are treated as unexpected.

Optional Feature:
- Macro: L1_RESPONSE_ROUTER_STATS_EN.
- Defined:
  - Adds output max_occupancy [$clog2(MAX_OUTSTANDING):0], a registered high-water mark of count. Reset 0; updated the cycle after count exceeds it.
  - Adds output words_routed [31:0], counting forwarded words. Reset 0; wraps at 2^32.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Single word: push id=1 len=0; next cycle rvalid with 0xDEADBEEF → one cycle later rd_valid=4'b0010, rd_data=0xDEADBEEF, rd_word_idx=0, rd_last=1; FIFO empty.
- Burst: push id=0 len=3; 4 back-to-back rvalids A0..A3 → rd_valid=4'b0001 for 4 consecutive cycles, rd_word_idx=0,1,2,3, rd_last only on the 4th word.
- Interleaved owners: push id=2 len=0, id=3 len=1, id=0 len=0; 4 words → rd_valid sequence 0100, 1000, 1000, 0001; protocol_error=0.
- Full/wrap:
  - Push 4 requests → req_full=1.
  - 5th push is ignored and sets protocol_error=1.
  - Drain all 4, then push 6 more with responses interleaved: IDs come out in order across pointer wrap.
- Unexpected response: rvalid with FIFO empty (also with same-cycle push) → rd_valid stays 0, protocol_error=1 and holds; rst clears it to 0.
- Reset mid-burst: push id=1 len=3, deliver 2 words, assert rst 1 cycle → rd_valid=0, req_full=0. A new push id=3 len=0 plus one word → rd_valid=4'b1000, rd_word_idx=0.
